// File: rtl/oven_pkg.sv
// Shared oven definitions: controller states, keypad codes and time limits.
package oven_pkg;

    localparam int unsigned TIME_W       = 13;
    localparam int unsigned SEC_PER_HOUR = 3600;
    localparam int unsigned MAX_SEC      = 3599;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_START = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_mmss_to_sec.sv
// Combinational MM:SS BCD to seconds converter with range check.
module bcd_mmss_to_sec
    import oven_pkg::*;
(
    input  logic [15:0]       i_bcd,
    output logic [TIME_W-1:0] o_sec,
    output logic              o_valid
);

    logic [TIME_W-1:0] w_min;
    logic [TIME_W-1:0] w_sec_part;

    always_comb begin
        w_min      = TIME_W'(i_bcd[15:12]) * TIME_W'(10) + TIME_W'(i_bcd[11:8]);
        w_sec_part = TIME_W'(i_bcd[7:4])   * TIME_W'(10) + TIME_W'(i_bcd[3:0]);
        o_sec      = w_min * TIME_W'(60) + w_sec_part;
        o_valid    = (w_min <= TIME_W'(59)) && (w_sec_part <= TIME_W'(59)) &&
                     (o_sec != '0);
    end

endmodule

// File: rtl/cook_time_entry.sv
// Keypad cook-time entry: collects MM:SS, validates on START, arms the oven timer.
module cook_time_entry #(
    parameter int unsigned TIME_W  = 13,
    parameter int unsigned MAX_SEC = 3599
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              cancel,
    input  logic              timer_done,
    output logic [TIME_W-1:0] cook_time,
    output logic              time_input_done,
    output logic [15:0]       digits,
    output logic [1:0]        state,
    output logic              entry_error
);

    localparam int unsigned CNT_W = 3;

    oven_pkg::state_t    r_state, w_state_nxt;
    logic [TIME_W-1:0]   r_cook_time, w_cook_time_nxt;
    logic                r_tid, w_tid_nxt;
    logic [15:0]         r_digits, w_digits_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic                r_err, w_err_nxt;

    logic                    w_is_digit, w_is_clear, w_is_start;
    logic [oven_pkg::TIME_W-1:0] w_sec;
    logic                    w_sec_valid;

    bcd_mmss_to_sec u_conv (
        .i_bcd   (r_digits),
        .o_sec   (w_sec),
        .o_valid (w_sec_valid)
    );

    assign w_is_digit = key_valid && (key_code <= 4'd9);
    assign w_is_clear = key_valid && (key_code == oven_pkg::KEY_CLEAR);
    assign w_is_start = key_valid && (key_code == oven_pkg::KEY_START);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= oven_pkg::ST_IDLE;
            r_cook_time <= '0;
            r_tid       <= 1'b0;
            r_digits    <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cook_time <= w_cook_time_nxt;
            r_tid       <= w_tid_nxt;
            r_digits    <= w_digits_nxt;
            r_count     <= w_count_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Priority per cycle: cancel, then CLEAR, then timer_done, then other keys.
    always_comb begin
        w_state_nxt     = r_state;
        w_cook_time_nxt = r_cook_time;
        w_tid_nxt       = r_tid;
        w_digits_nxt    = r_digits;
        w_count_nxt     = r_count;
        w_err_nxt       = 1'b0;

        case (r_state)
            oven_pkg::ST_IDLE: begin
                if (!cancel && w_is_digit) begin
                    w_digits_nxt = {r_digits[11:0], key_code};
                    w_count_nxt  = CNT_W'(1);
                    w_state_nxt  = oven_pkg::ST_ENTRY;
                end
            end
            oven_pkg::ST_ENTRY: begin
                if (cancel || w_is_clear) begin
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                    w_state_nxt  = oven_pkg::ST_IDLE;
                end else if (w_is_digit) begin
                    if (r_count < CNT_W'(4)) begin
                        w_digits_nxt = {r_digits[11:0], key_code};
                        w_count_nxt  = r_count + CNT_W'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_is_start) begin
                    if (w_sec_valid && (32'(w_sec) <= MAX_SEC)) begin
                        w_cook_time_nxt = TIME_W'(w_sec);
                        w_tid_nxt       = 1'b1;
                        w_state_nxt     = oven_pkg::ST_ARMED;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            oven_pkg::ST_ARMED, oven_pkg::ST_FINISHED: begin
                if (cancel || w_is_clear) begin
                    w_state_nxt     = oven_pkg::ST_IDLE;
                    w_cook_time_nxt = '0;
                    w_tid_nxt       = 1'b0;
                    w_digits_nxt    = '0;
                    w_count_nxt     = '0;
                end else if (r_state == oven_pkg::ST_ARMED && timer_done) begin
                    w_state_nxt = oven_pkg::ST_FINISHED;
                end
            end
            default: w_state_nxt = oven_pkg::ST_IDLE;
        endcase
    end

    assign cook_time       = r_cook_time;
    assign time_input_done = r_tid;
    assign digits          = r_digits;
    assign state           = 2'(r_state);
    assign entry_error     = r_err;

endmodule

// File: tb/tb_cook_time_entry.sv
// Directed self-checking bench for cook_time_entry.
module tb_cook_time_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        cancel;
    logic        timer_done;
    logic [12:0] cook_time;
    logic        time_input_done;
    logic [15:0] digits;
    logic [1:0]  state;
    logic        entry_error;

    int n_checks = 0;
    int n_fail   = 0;

    cook_time_entry #(.TIME_W(13), .MAX_SEC(3599)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .cancel          (cancel),
        .timer_done      (timer_done),
        .cook_time       (cook_time),
        .time_input_done (time_input_done),
        .digits          (digits),
        .state           (state),
        .entry_error     (entry_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive for one cycle between falling edges; returns just after the sampling edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd15;
    endtask

    task automatic pulse(input logic c, input logic td);
        @(negedge clk);
        cancel     = c;
        timer_done = td;
        @(negedge clk);
        cancel     = 1'b0;
        timer_done = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_tid"},   32'(time_input_done), 32'd0);
        check({tag, "_ct"},    32'(cook_time), 32'd0);
        check({tag, "_dig"},   32'(digits), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd15;
        cancel = 1'b0; timer_done = 1'b0;
        #12;
        check_idle("rst");
        check("rst_err", 32'(entry_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // START and CLEAR in IDLE do nothing
        press(4'd11);
        check("idle_start_state", 32'(state), 32'd0);
        check("idle_start_err", 32'(entry_error), 32'd0);

        // 1,3,0 START -> 90 s
        press(4'd1); press(4'd3); press(4'd0);
        check("e130_dig", 32'(digits), 32'h0130);
        check("e130_state", 32'(state), 32'd1);
        press(4'd11);
        check("e130_ct", 32'(cook_time), 32'd90);
        check("e130_tid", 32'(time_input_done), 32'd1);
        check("e130_state_armed", 32'(state), 32'd2);

        // digit and START ignored while armed
        press(4'd5);
        press(4'd11);
        check("armed_key_ct", 32'(cook_time), 32'd90);
        check("armed_key_state", 32'(state), 32'd2);
        check("armed_key_err", 32'(entry_error), 32'd0);

        pulse(1'b0, 1'b1);
        check("fin_state", 32'(state), 32'd3);
        check("fin_tid", 32'(time_input_done), 32'd1);
        press(4'd4);
        check("fin_key_state", 32'(state), 32'd3);
        press(4'd10);
        check_idle("fin_clear");

        // 59:59 -> 3599
        press(4'd5); press(4'd9); press(4'd5); press(4'd9); press(4'd11);
        check("e5959_ct", 32'(cook_time), 32'd3599);
        check("e5959_state", 32'(state), 32'd2);
        pulse(1'b1, 1'b0);
        check_idle("armed_cancel");

        // 60:00 rejected
        press(4'd6); press(4'd0); press(4'd0); press(4'd0); press(4'd11);
        check("e6000_err", 32'(entry_error), 32'd1);
        check("e6000_state", 32'(state), 32'd1);
        check("e6000_dig", 32'(digits), 32'h6000);
        @(negedge clk);
        check("e6000_err_drop", 32'(entry_error), 32'd0);
        press(4'd10);
        check("e6000_clear_state", 32'(state), 32'd0);

        // 00:90 rejected (seconds out of range)
        press(4'd9); press(4'd0); press(4'd11);
        check("e90_err", 32'(entry_error), 32'd1);
        check("e90_state", 32'(state), 32'd1);
        pulse(1'b1, 1'b0);
        check_idle("entry_cancel");

        // zero time rejected
        press(4'd0); press(4'd0); press(4'd11);
        check("e00_err", 32'(entry_error), 32'd1);
        check("e00_ct", 32'(cook_time), 32'd0);
        press(4'd10);

        // fifth digit rejected, then 12:34 -> 754
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("e5th_err", 32'(entry_error), 32'd1);
        check("e5th_dig", 32'(digits), 32'h1234);
        press(4'd11);
        check("e1234_ct", 32'(cook_time), 32'd754);
        check("e1234_err", 32'(entry_error), 32'd0);

        // cancel beats timer_done
        pulse(1'b1, 1'b1);
        check_idle("cancel_vs_done");

        // ignored codes and stray timer_done in IDLE
        press(4'd13);
        check("code13_state", 32'(state), 32'd0);
        check("code13_err", 32'(entry_error), 32'd0);
        pulse(1'b0, 1'b1);
        check("idle_done_state", 32'(state), 32'd0);

        // async reset mid-entry
        press(4'd4);
        check("pre_rst_state", 32'(state), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd7); press(4'd11);
        check("e7_ct", 32'(cook_time), 32'd7);
        check("e7_tid", 32'(time_input_done), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
